// File: rtl/pc_pkg.sv
// Shared types and default vectors for the MIPS fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_JR   = 3'd3,
    SRC_EXC  = 3'd4,
    SRC_ERET = 3'd5
  } pc_src_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular history of non-sequential PC targets; read index 0 is the newest entry.
module pc_trace_buf #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]        rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + IDX_W'(1);
    end
  end

  // wr_ptr points at the slot after the newest write, so step back one first
  assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: next-PC select, stall/halt FSM, EPC and fetch counter.
// Optional PC_TRACE_EN builds a history buffer of redirect targets.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                JMP_W       = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC   = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC     = EXC_VEC_DEF,
  parameter int                TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           jmp,
  input  logic                           jr,
  input  logic [15:0]                    imm,
  input  logic [JMP_W-1:0]               jmp_dest,
  input  logic [ADDR_W-1:0]              rs,
  input  logic                           exc_req,
  input  logic                           eret,
  input  logic                           halt_req,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              seq_addr,
  output logic [ADDR_W-1:0]              epc,
  output logic                           fetch_valid,
  output logic                           halted,
  output logic                           misalign,
  output logic [31:0]                    instr_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_data
);

  pc_state_t         state, state_next;
  pc_src_t           pc_src;
  logic              pc_load;
  logic              misalign_next;
  logic              cnt_en;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign seq_addr = pc + ADDR_W'(4);
  assign imm_ext  = {{(ADDR_W-16){imm[15]}}, imm};
  assign br_tgt   = seq_addr + (imm_ext << 2);
  assign j_tgt    = {pc[ADDR_W-1:JMP_W+2], jmp_dest, 2'b00};

  assign fetch_valid = (state == ST_RUN) && !stall;
  assign halted      = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  // Exception and eret outrank stall/halt; halt outranks every other redirect
  always_comb begin
    state_next    = state;
    pc_load       = 1'b0;
    pc_src        = SRC_SEQ;
    misalign_next = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (exc_req) begin
          pc_load = 1'b1;
          pc_src  = SRC_EXC;
        end else if (eret) begin
          pc_load = 1'b1;
          pc_src  = SRC_ERET;
        end else if (halt_req || stall) begin
          pc_load = 1'b0;
        end else if (jmp && jr) begin
          pc_load = 1'b1;
          if (rs[1:0] != 2'b00) begin
            pc_src        = SRC_EXC;
            misalign_next = 1'b1;
          end else begin
            pc_src = SRC_JR;
          end
        end else if (jmp) begin
          pc_load = 1'b1;
          pc_src  = SRC_J;
        end else if (branch) begin
          pc_load = 1'b1;
          pc_src  = SRC_BR;
        end else begin
          pc_load = 1'b1;
          pc_src  = SRC_SEQ;
        end
        if (halt_req && !exc_req) state_next = ST_HALT;
        cnt_en = !stall && (state_next == ST_RUN);
      end
      ST_HALT: begin
        if (exc_req) begin
          state_next = ST_RUN;
          pc_load    = 1'b1;
          pc_src     = SRC_EXC;
        end else if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_next = seq_addr;
    case (pc_src)
      SRC_BR:   pc_next = br_tgt;
      SRC_J:    pc_next = j_tgt;
      SRC_JR:   pc_next = rs;
      SRC_EXC:  pc_next = EXC_VEC;
      SRC_ERET: pc_next = epc;
      default:  pc_next = seq_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      epc       <= '0;
      misalign  <= 1'b0;
      instr_cnt <= '0;
    end else begin
      misalign <= misalign_next;
      if (pc_load) pc <= pc_next;
      if (pc_load && pc_src == SRC_EXC) epc <= pc;
      if (cnt_en) instr_cnt <= instr_cnt + 32'd1;
    end
  end

`ifdef PC_TRACE_EN
  pc_trace_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pc_load && pc_src != SRC_SEQ),
    .wr_data (pc_next),
    .rd_idx  (trace_idx),
    .rd_data (trace_data)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_data       = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;
  import pc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, jmp, jr, exc_req, eret, halt_req, resume;
  logic [15:0] imm;
  logic [25:0] jmp_dest;
  logic [31:0] rs;
  logic [31:0] pc, seq_addr, epc, instr_cnt, trace_data;
  logic        fetch_valid, halted, misalign;
  logic [2:0]  trace_idx;

  int compared   = 0;
  int mismatched = 0;

  pc_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch      (branch),
    .jmp         (jmp),
    .jr          (jr),
    .imm         (imm),
    .jmp_dest    (jmp_dest),
    .rs          (rs),
    .exc_req     (exc_req),
    .eret        (eret),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .seq_addr    (seq_addr),
    .epc         (epc),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .misalign    (misalign),
    .instr_cnt   (instr_cnt),
    .trace_idx   (trace_idx),
    .trace_data  (trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1ns after the last one
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; branch = 0; jmp = 0; jr = 0; exc_req = 0;
    eret = 0; halt_req = 0; resume = 0; imm = '0; jmp_dest = '0; rs = '0;
    trace_idx = '0;

    applyStimulus(2);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_fv", {31'b0, fetch_valid}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("rst_cnt", instr_cnt, 32'd0);
    checkOutput("rst_trace", trace_data, 32'h0);

    rst_n = 1'b1;
    #1;
    checkOutput("boot_fv", {31'b0, fetch_valid}, 32'd0);
    checkOutput("boot_pc", pc, 32'h0);
    applyStimulus(1);
    checkOutput("run0_pc", pc, 32'h0);
    checkOutput("run0_fv", {31'b0, fetch_valid}, 32'd1);
    checkOutput("run0_seq", seq_addr, 32'h4);
    applyStimulus(1);
    checkOutput("run1_pc", pc, 32'h4);
    applyStimulus(1);
    checkOutput("run2_pc", pc, 32'h8);
    applyStimulus(1);
    checkOutput("run3_pc", pc, 32'hC);
    checkOutput("run3_cnt", instr_cnt, 32'd3);

    jmp = 1; jmp_dest = 26'h40;
    applyStimulus(1);
    checkOutput("j100_pc", pc, 32'h100);
    jmp = 0; branch = 1; imm = 16'hFFFE;
    applyStimulus(1);
    checkOutput("br_neg_pc", pc, 32'hFC);
    branch = 0; jmp = 1; jmp_dest = 26'h40;
    applyStimulus(1);
    jmp = 0; branch = 1; imm = 16'h0003;
    applyStimulus(1);
    checkOutput("br_pos_pc", pc, 32'h110);
    checkOutput("br_cnt", instr_cnt, 32'd7);

    branch = 0; jmp = 1; jr = 1; rs = 32'hF000_0010;
    applyStimulus(1);
    checkOutput("jr_hi_pc", pc, 32'hF000_0010);
    jr = 0; jmp_dest = 26'h40; branch = 1; imm = 16'h0003;
    applyStimulus(1);
    checkOutput("j_over_br_pc", pc, 32'hF000_0100);
    checkOutput("j_seq", seq_addr, 32'hF000_0104);
    checkOutput("j_cnt", instr_cnt, 32'd9);

    branch = 0; jr = 1; rs = 32'h40;
    applyStimulus(1);
    checkOutput("jr40_pc", pc, 32'h40);
    rs = 32'h2002;
    applyStimulus(1);
    checkOutput("mis_pc", pc, 32'h80);
    checkOutput("mis_epc", epc, 32'h40);
    checkOutput("mis_pulse", {31'b0, misalign}, 32'd1);
    jmp = 0; jr = 0;
    applyStimulus(1);
    checkOutput("mis_clear", {31'b0, misalign}, 32'd0);
    checkOutput("mis_next_pc", pc, 32'h84);
    eret = 1;
    applyStimulus(1);
    checkOutput("eret_pc", pc, 32'h40);
    checkOutput("eret_cnt", instr_cnt, 32'd13);
`ifdef PC_TRACE_EN
    checkOutput("trace_new", trace_data, 32'h40);
    trace_idx = 3'd1;
    #1;
    checkOutput("trace_prev", trace_data, 32'h80);
    trace_idx = 3'd0;
`else
    checkOutput("trace_off", trace_data, 32'h0);
`endif
    eret = 0;

    jmp = 1; jr = 1; rs = 32'h200;
    applyStimulus(1);
    checkOutput("jr200_pc", pc, 32'h200);
    jmp = 0; jr = 0; stall = 1; exc_req = 1;
    #1;
    checkOutput("stall_fv", {31'b0, fetch_valid}, 32'd0);
    applyStimulus(1);
    checkOutput("exc_stall_pc", pc, 32'h80);
    checkOutput("exc_stall_epc", epc, 32'h200);
    checkOutput("exc_stall_cnt", instr_cnt, 32'd14);
    exc_req = 0;
    applyStimulus(2);
    checkOutput("stall_pc", pc, 32'h80);
    checkOutput("stall_cnt", instr_cnt, 32'd14);
    stall = 0;

    jmp = 1; jr = 1; rs = 32'h30;
    applyStimulus(1);
    checkOutput("jr30_pc", pc, 32'h30);
    jmp = 0; jr = 0; halt_req = 1;
    applyStimulus(1);
    checkOutput("halt_flag", {31'b0, halted}, 32'd1);
    checkOutput("halt_pc0", pc, 32'h30);
    halt_req = 0; branch = 1; jmp = 1; eret = 1;
    applyStimulus(4);
    checkOutput("halt_pc5", pc, 32'h30);
    checkOutput("halt_fv", {31'b0, fetch_valid}, 32'd0);
    checkOutput("halt_cnt", instr_cnt, 32'd15);
    branch = 0; jmp = 0; eret = 0; resume = 1; exc_req = 1;
    applyStimulus(1);
    checkOutput("hexc_pc", pc, 32'h80);
    checkOutput("hexc_epc", epc, 32'h30);
    checkOutput("hexc_halted", {31'b0, halted}, 32'd0);
    resume = 0; exc_req = 0;
    applyStimulus(1);
    checkOutput("post_exc_pc", pc, 32'h84);
    halt_req = 1;
    applyStimulus(1);
    halt_req = 0; resume = 1;
    applyStimulus(1);
    checkOutput("resume_halted", {31'b0, halted}, 32'd0);
    checkOutput("resume_pc", pc, 32'h84);
    resume = 0;
    applyStimulus(1);
    checkOutput("resume_next_pc", pc, 32'h88);
    checkOutput("resume_cnt", instr_cnt, 32'd17);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_epc", epc, 32'h0);
    checkOutput("async_cnt", instr_cnt, 32'd0);
    applyStimulus(1);
    rst_n = 1'b1;
    #1;
    checkOutput("reboot_fv", {31'b0, fetch_valid}, 32'd0);
    applyStimulus(1);
    checkOutput("reboot_run_fv", {31'b0, fetch_valid}, 32'd1);
    applyStimulus(1);
    checkOutput("reboot_pc", pc, 32'h4);
    checkOutput("reboot_cnt", instr_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Registered program-counter generator for the MIPS fetch stage. It owns the PC register and selects the next PC from five sources: sequential, branch, jump, jump-register and exception/return vectors. It also supports stall, halt and resume, detects misaligned jr targets, captures the EPC, and counts retired fetches. It sits between the decode/control logic and the instruction memory address port.

Parameters:
ADDR_W, 32, PC/address width; must be >= JMP_W+2
JMP_W, 26, width of the j/jal target field
RESET_VEC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0080, exception handler entry address
TRACE_DEPTH, 8, trace buffer entries (power of 2; used only with PC_TRACE_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC (pipeline bubble)
branch  in  1  conditional branch taken
jmp  in  1  jump (j/jal/jr)
jr  in  1  with jmp: target comes from rs
imm  in  16  raw branch immediate
jmp_dest  in  JMP_W  jump target field
rs  in  ADDR_W  register value for jr
exc_req  in  1  take exception
eret  in  1  return from exception
halt_req  in  1  enter HALT
resume  in  1  leave HALT
pc  out  ADDR_W  current fetch address (registered)
seq_addr  out  ADDR_W  pc+4 (link value for jal)
epc  out  ADDR_W  exception PC (registered)
fetch_valid  out  1  pc is a valid fetch this cycle
halted  out  1  FSM in HALT
misalign  out  1  one-cycle pulse: misaligned jr trapped
instr_cnt  out  32  count of advancing fetches
trace_idx  in  log2(TRACE_DEPTH)  trace read index (0 = newest)
trace_data  out  ADDR_W  trace entry at trace_idx

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: pc=RESET_VEC, epc=0, misalign=0, instr_cnt=0, halted=0, fetch_valid=0, FSM=BOOT. Trace entries reset to 0.
- FSM states: BOOT, RUN, HALT.
  - BOOT lasts exactly one cycle with fetch_valid=0, then moves to RUN.
  - In RUN, fetch_valid=~stall.
  - In HALT, fetch_valid=0 and halted=1.
- Arithmetic (all modulo 2^ADDR_W):
  - seq = pc+4
  - br_tgt = seq + (sign_extend(imm)<<2)
  - j_tgt = {pc[ADDR_W-1:JMP_W+2], jmp_dest, 2'b00}
  - jr_tgt = rs
- Next-PC priority in RUN (highest first):
  1. exc_req: pc<=EXC_VEC, epc<=pc. Overrides stall.
  2. eret: pc<=epc. Overrides stall.
  3. stall: pc holds.
  4. jmp&jr: if rs[1:0]!=0 then pc<=EXC_VEC, epc<=pc, misalign pulses 1 on the next cycle; else pc<=rs.
  5. jmp&~jr: pc<=j_tgt.
  6. branch: pc<=br_tgt.
  7. otherwise pc<=seq.
- Simultaneous jmp and branch: jmp wins. jr without jmp is ignored.
- halt_req in RUN without exc_req: FSM moves to HALT and pc holds (the halt takes priority over the redirect sources ranked 3-7 above).
- In HALT:
  - resume: back to RUN, pc unchanged.
  - exc_req: back to RUN with the exception taken as above; it beats resume.
  - All other inputs are ignored.
- instr_cnt increments by 1 on every clock edge where fetch_valid=1 and the FSM stays in RUN; it wraps to 0 after 2^32-1.
- Reset asserted mid-operation clears everything asynchronously; the first fetch after reset release comes one cycle after BOOT.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: on every cycle where pc is loaded from a non-sequential source (branch, jmp, exception, eret), the new target is written into a TRACE_DEPTH-entry circular buffer. trace_data is combinational: the entry at trace_idx counting back from the newest write. Before the buffer fills, unwritten entries read 0; once full, the oldest entry is overwritten.
- Undefined: no storage is built; trace_data is tied to 0. Ports remain present.

Decomposition:
- Package pc_pkg holds:
  - FSM state enum (BOOT/RUN/HALT)
  - next-PC source select enum (SEQ/BR/J/JR/EXC/ERET)
  - default vector constants
- One natural sub-module: pc_trace_buf, the circular buffer, instantiated only under PC_TRACE_EN.

Test Plan:
- Reset with RESET_VEC=0: release rst_n -> pc=0, fetch_valid=0 for 1 cycle, then pc=0,4,8 on consecutive cycles and instr_cnt=3 after three advances.
- Branch at pc=0x100, imm=16'hFFFE -> next pc=0xFC. At pc=0x100 with imm=16'h0003 -> next pc=0x110.
- pc=0xF000_0010, jmp=1, jmp_dest=0x0000040 -> pc=0xF000_0100. Same cycle with branch=1 -> still 0xF000_0100.
- jr with rs=0x2002 at pc=0x40 -> pc=0x80, epc=0x40, misalign=1 for exactly one cycle. A subsequent eret -> pc=0x40.
- stall=1 and exc_req=1 at pc=0x200 -> pc=0x80, epc=0x200. Stall alone holds pc and instr_cnt.
- halt_req at pc=0x30 -> halted=1, pc stays 0x30 for 5 cycles; then resume and exc_req together -> pc=0x80, epc=0x30, halted=0.
